// File: rtl/branch_predict_ctrl.sv
// rtl/branch_predict_ctrl.sv - 2-bit counter branch predictor with mispredict redirect/flush sequencing
// Optional BP_STATS_EN builds saturating resolved-branch and mispredict counters.
module branch_predict_ctrl #(
  parameter int XLEN         = 32,
  parameter int IDX_BITS     = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic            if_is_branch,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_pred_taken,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic            busy,
  output logic [15:0]     stat_branches,
  output logic [15:0]     stat_mispredicts
);

  localparam int ENTRIES = 1 << IDX_BITS;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              redirect_q, redirect_d;
  logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
  logic              flush_q, flush_d;
  logic [1:0]        tbl_q [ENTRIES];
  logic [1:0]        tbl_d [ENTRIES];

  logic [IDX_BITS-1:0] if_idx;
  logic [IDX_BITS-1:0] ex_idx;
  logic                resolve;
  logic                mispredict;
  logic                unused_if_pc;

  assign if_idx       = if_pc[IDX_BITS+1:2];
  assign ex_idx       = ex_pc[IDX_BITS+1:2];
  assign unused_if_pc = ^{if_pc[XLEN-1:IDX_BITS+2], if_pc[1:0]};

  // Wrong-path instructions arriving during FLUSH must not train or count.
  assign resolve    = (state_q == IDLE) & ex_valid & ex_is_branch;
  assign mispredict = resolve & (ex_pred_taken != ex_taken);

  assign pred_taken = if_valid & if_is_branch & tbl_q[if_idx][1];

  always_comb begin
    tbl_d = tbl_q;
    if (resolve) begin
      if (ex_taken && tbl_q[ex_idx] != 2'b11) begin
        tbl_d[ex_idx] = tbl_q[ex_idx] + 2'd1;
      end else if (!ex_taken && tbl_q[ex_idx] != 2'b00) begin
        tbl_d[ex_idx] = tbl_q[ex_idx] - 2'd1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    flush_d       = flush_q;
    case (state_q)
      IDLE: begin
        if (mispredict) begin
          state_d       = FLUSH;
          redirect_d    = 1'b1;
          redirect_pc_d = ex_taken ? ex_target : ex_pc + XLEN'(4);
          flush_d       = 1'b1;
          cnt_d         = 3'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (cnt_q == 3'd0) begin
          state_d = IDLE;
          flush_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= 3'd0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      flush_q       <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_q[i] <= 2'b01;
      end
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      flush_q       <= flush_d;
      tbl_q         <= tbl_d;
    end
  end

  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign flush_if_id = flush_q;
  assign flush_id_ex = flush_q;
  assign busy        = (state_q == FLUSH);

`ifdef BP_STATS_EN
  logic [15:0] stat_br_q, stat_br_d;
  logic [15:0] stat_mp_q, stat_mp_d;

  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (resolve && stat_br_q != 16'hFFFF) stat_br_d = stat_br_q + 16'd1;
    if (mispredict && stat_mp_q != 16'hFFFF) stat_mp_d = stat_mp_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_br_q <= 16'h0000;
      stat_mp_q <= 16'h0000;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`else
  assign stat_branches    = 16'h0000;
  assign stat_mispredicts = 16'h0000;
`endif

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// tb/tb_branch_predict_ctrl.sv - directed and randomized checks of branch_predict_ctrl against a behavioural model
module tb_branch_predict_ctrl;

  localparam int FLUSH_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid, if_is_branch;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic        ex_valid, ex_is_branch, ex_pred_taken, ex_taken;
  logic [31:0] ex_pc, ex_target;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush_if_id, flush_id_ex, busy;
  logic [15:0] stat_branches, stat_mispredicts;

  branch_predict_ctrl #(.XLEN(32), .IDX_BITS(4), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_is_branch(if_is_branch), .if_pc(if_pc),
    .pred_taken(pred_taken),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc),
    .ex_pred_taken(ex_pred_taken), .ex_taken(ex_taken), .ex_target(ex_target),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .busy(busy),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // behavioural model: counters as small ints, flush window as cycles remaining
  int          m_ctr [16];
  int          m_flush_left;
  bit          m_redir;
  logic [31:0] m_rpc;
  int          m_br, m_mp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else pass_cnt++;
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_ctr[i] = 1;
    m_flush_left = 0;
    m_redir = 0;
    m_rpc = 32'h0;
    m_br = 0;
    m_mp = 0;
  endtask

  task automatic cyc(input bit rn, input bit iv, input bit ib, input logic [31:0] ipc,
                     input bit ev, input bit eb, input logic [31:0] epc,
                     input bit ept, input bit et, input logic [31:0] etg);
    int i;
    rst_n = rn; if_valid = iv; if_is_branch = ib; if_pc = ipc;
    ex_valid = ev; ex_is_branch = eb; ex_pc = epc;
    ex_pred_taken = ept; ex_taken = et; ex_target = etg;
    @(negedge clk);
    check("pred_taken", {31'b0, pred_taken}, {31'b0, iv & ib & (m_ctr[idx_of(ipc)] >= 2)});
    check("redirect", {31'b0, redirect}, {31'b0, m_redir});
    check("redirect_pc", redirect_pc, m_rpc);
    check("flush_if_id", {31'b0, flush_if_id}, {31'b0, m_flush_left > 0});
    check("flush_id_ex", {31'b0, flush_id_ex}, {31'b0, m_flush_left > 0});
    check("busy", {31'b0, busy}, {31'b0, m_flush_left > 0});
`ifdef BP_STATS_EN
    check("stat_branches", {16'b0, stat_branches}, (m_br > 65535) ? 32'hFFFF : m_br);
    check("stat_mispredicts", {16'b0, stat_mispredicts}, (m_mp > 65535) ? 32'hFFFF : m_mp);
`else
    check("stat_branches", {16'b0, stat_branches}, 32'h0);
    check("stat_mispredicts", {16'b0, stat_mispredicts}, 32'h0);
`endif
    @(posedge clk);
    if (!rn) begin
      model_reset();
    end else begin
      m_redir = 0;
      if (m_flush_left > 0) begin
        m_flush_left--;
      end else if (ev && eb) begin
        i = idx_of(epc);
        if (et) m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
        else    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        m_br++;
        if (ept != et) begin
          m_redir = 1;
          m_rpc = et ? etg : epc + 32'd4;
          m_flush_left = FLUSH_CYCLES;
          m_mp++;
        end
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0);
  endtask

  task automatic branch(input logic [31:0] pc, input bit pt, input bit t, input logic [31:0] tg);
    cyc(1, 0, 0, 32'h0, 1, 1, pc, pt, t, tg);
  endtask

  initial begin
    rst_n = 1'b0;
    if_valid = 0; if_is_branch = 0; if_pc = 0;
    ex_valid = 0; ex_is_branch = 0; ex_pc = 0; ex_pred_taken = 0; ex_taken = 0; ex_target = 0;
    model_reset();
    @(posedge clk); #1;

    cyc(0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0);
    cyc(0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0);
    cyc(1, 1, 1, 32'h100, 0, 0, 32'h0, 0, 0, 32'h0);
    check("probe_after_reset", {31'b0, pred_taken}, 32'h0);

    branch(32'h100, 0, 1, 32'h40);
    idle(FLUSH_CYCLES);
    branch(32'h100, 1, 1, 32'h40);
    branch(32'h100, 1, 1, 32'h40);
    cyc(1, 1, 1, 32'h100, 0, 0, 32'h0, 0, 0, 32'h0);
    check("trained_0x100", {31'b0, pred_taken}, 32'h1);
    cyc(1, 1, 1, 32'h104, 0, 0, 32'h0, 0, 0, 32'h0);
    check("untrained_0x104", {31'b0, pred_taken}, 32'h0);

    branch(32'h200, 0, 1, 32'h180);
    check("mp_taken_redirect", {31'b0, redirect}, 32'h1);
    check("mp_taken_pc", redirect_pc, 32'h180);
    idle(FLUSH_CYCLES + 1);

    branch(32'hFFFF_FFFC, 1, 0, 32'h1234);
    check("wrap_pc", redirect_pc, 32'h0);
    branch(32'h300, 0, 1, 32'h500);
    check("ignored_in_flush", {31'b0, redirect}, 32'h0);
    idle(FLUSH_CYCLES + 1);

    branch(32'h400, 0, 1, 32'h480);
    idle(1);
    cyc(0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0);
    check("rst_mid_flush_busy", {31'b0, busy}, 32'h0);
    check("rst_mid_flush_flush", {31'b0, flush_if_id}, 32'h0);
    cyc(1, 1, 1, 32'h100, 0, 0, 32'h0, 0, 0, 32'h0);
    check("rst_clears_table", {31'b0, pred_taken}, 32'h0);

    branch(32'h10, 0, 0, 32'h0);
    branch(32'h14, 0, 1, 32'h80);
    idle(FLUSH_CYCLES);
    branch(32'h18, 0, 0, 32'h0);
    branch(32'h1C, 1, 0, 32'h0);
    idle(FLUSH_CYCLES);
    branch(32'h20, 0, 0, 32'h0);
    cyc(1, 0, 0, 32'h0, 1, 0, 32'h24, 0, 1, 32'h0);
`ifdef BP_STATS_EN
    check("stats_branches", {16'b0, stat_branches}, 32'd5);
    check("stats_mispredicts", {16'b0, stat_mispredicts}, 32'd2);
`else
    check("stats_branches_off", {16'b0, stat_branches}, 32'd0);
    check("stats_mispredicts_off", {16'b0, stat_mispredicts}, 32'd0);
`endif

    for (int n = 0; n < 2000; n++) begin
      cyc($urandom_range(0, 199) != 0,
          1'($urandom), 1'($urandom), {$urandom_range(0, 3) == 0 ? 26'($urandom) : 26'($urandom_range(0, 31)), 2'($urandom)} & 32'hFFFF_FFFC | 32'($urandom_range(0, 3)) & 32'h0,
          $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
          ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : {24'h0, 6'($urandom_range(0, 63)), 2'b00},
          1'($urandom), 1'($urandom), $urandom);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
